// File: rtl/tcdm_varlat_bank_adapter.sv
// tcdm_varlat_bank_adapter
//
// Target-side stage between one output port of the variable-latency crossbar
// and a fixed-latency SRAM bank. The flat request payload {wen, be, addr, wdata}
// is unpacked into SRAM control fields. A {valid, is_write} shift register,
// MemLatency stages deep, follows each accepted access to the cycle where the
// bank returns read data. The response is then registered onto vld_o/rdata_o,
// so vld_o pulses exactly MemLatency+1 cycles after the accepting cycle.
//
// Optional feature, selected by the macro TCDM_BANK_INIT_EN:
//   When defined, reset enters an INIT state. In INIT the bank is zero-filled,
//   one word per cycle, before any grant is issued. When undefined, there is no
//   INIT state and no sweep counter.

module tcdm_varlat_bank_adapter #(
    parameter int unsigned AddrWidth    = 10,
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned BeWidth      = DataWidth / 8,
    parameter int unsigned ReqDataWidth = 1 + BeWidth + AddrWidth + DataWidth,
    parameter int unsigned MemLatency   = 1,
    parameter int unsigned WriteResp    = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_i,
    output logic                    gnt_o,
    input  logic [ReqDataWidth-1:0] data_i,
    output logic                    vld_o,
    output logic [DataWidth-1:0]    rdata_o,
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [BeWidth-1:0]      mem_be_o,
    output logic [AddrWidth-1:0]    mem_addr_o,
    output logic [DataWidth-1:0]    mem_wdata_o,
    input  logic [DataWidth-1:0]    mem_rdata_i,
    input  logic                    mem_stall_i,
    output logic                    init_done_o
);

    // Payload field positions, MSB first: {wen, be, addr, wdata}.
    localparam int unsigned AddrLsb = DataWidth;
    localparam int unsigned BeLsb   = DataWidth + AddrWidth;
    localparam int unsigned WenBit  = DataWidth + AddrWidth + BeWidth;

    localparam logic WriteRespEn = (WriteResp != 0);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

`ifdef TCDM_BANK_INIT_EN
    localparam state_e ResetState = ST_INIT;
`else
    localparam state_e ResetState = ST_RUN;
`endif

    // ------------------------------------------------------------------
    // Payload unpacking
    // ------------------------------------------------------------------
    logic                 req_wen;
    logic [BeWidth-1:0]   req_be;
    logic [AddrWidth-1:0] req_addr;
    logic [DataWidth-1:0] req_wdata;

    assign req_wen   = data_i[WenBit];
    assign req_be    = data_i[BeLsb +: BeWidth];
    assign req_addr  = data_i[AddrLsb +: AddrWidth];
    assign req_wdata = data_i[DataWidth-1:0];

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    state_e state_q, state_d;
    logic   init_done_q;
    logic   accept;

`ifdef TCDM_BANK_INIT_EN
    logic [AddrWidth-1:0] init_cnt_q, init_cnt_d;
    logic                 init_write;
    logic                 init_last;

    // A sweep write happens in every non-stalled INIT cycle outside reset.
    assign init_write = rst_ni & (state_q == ST_INIT) & ~mem_stall_i;
    assign init_last  = (init_cnt_q == {AddrWidth{1'b1}});

    // The sweep counter advances only on cycles that actually write.
    always_comb begin
        init_cnt_d = init_cnt_q;
        if (init_write) begin
            init_cnt_d = init_cnt_q + 1'b1;
        end
    end

    // Sweep counter register; it wraps to 0 after the last address, which is harmless because RUN never returns to INIT.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            init_cnt_q <= '0;
        end else begin
            init_cnt_q <= init_cnt_d;
        end
    end
`endif

    // Next-state logic: leave INIT right after the write to the last address.
    always_comb begin
        state_d = state_q;
`ifdef TCDM_BANK_INIT_EN
        if ((state_q == ST_INIT) && init_write && init_last) begin
            state_d = ST_RUN;
        end
`else
        state_d = ST_RUN;
`endif
    end

    // State register and the registered ready flag, which mirrors the state being entered.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= ResetState;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_done_q <= (state_d == ST_RUN);
        end
    end

    assign init_done_o = init_done_q;

    // ------------------------------------------------------------------
    // Grant and SRAM drive (combinational, as the crossbar arbiter needs)
    // ------------------------------------------------------------------
    // Grant is withheld while in reset so that the bank sees no access in a reset cycle.
    always_comb begin
        accept      = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (rst_ni) begin
            if (state_q == ST_RUN) begin
                accept = req_i & ~mem_stall_i;
                if (accept) begin
                    mem_req_o   = 1'b1;
                    mem_we_o    = req_wen;
                    mem_be_o    = req_be;
                    mem_addr_o  = req_addr;
                    mem_wdata_o = req_wdata;
                end
            end
`ifdef TCDM_BANK_INIT_EN
            else if (init_write) begin
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_be_o    = '1;
                mem_addr_o  = init_cnt_q;
                mem_wdata_o = '0;
            end
`endif
        end
    end

    assign gnt_o = accept;

    // ------------------------------------------------------------------
    // Tracking pipeline: one {valid, is_write} entry per SRAM latency cycle
    // ------------------------------------------------------------------
    logic [MemLatency-1:0] pipe_vld_q, pipe_vld_d;
    logic [MemLatency-1:0] pipe_wr_q,  pipe_wr_d;

    assign pipe_vld_d[0] = accept;
    assign pipe_wr_d[0]  = accept & req_wen;

    genvar gi;
    generate
        for (gi = 1; gi < MemLatency; gi++) begin : g_pipe_shift
            assign pipe_vld_d[gi] = pipe_vld_q[gi-1];
            assign pipe_wr_d[gi]  = pipe_wr_q[gi-1];
        end
    endgenerate

    // Pipeline register; reset drops every in-flight transaction.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pipe_vld_q <= '0;
            pipe_wr_q  <= '0;
        end else begin
            pipe_vld_q <= pipe_vld_d;
            pipe_wr_q  <= pipe_wr_d;
        end
    end

    // ------------------------------------------------------------------
    // Response register
    // ------------------------------------------------------------------
    logic                 tail_vld;
    logic                 tail_wr;
    logic                 vld_q;
    logic [DataWidth-1:0] rdata_q;

    assign tail_vld = pipe_vld_q[MemLatency-1];
    assign tail_wr  = pipe_wr_q[MemLatency-1];

    // Capture bank data at the pipeline tail; writes answer with zero data, and only if write responses are enabled.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            vld_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            vld_q   <= tail_vld & (~tail_wr | WriteRespEn);
            rdata_q <= (tail_vld & ~tail_wr) ? mem_rdata_i : '0;
        end
    end

    assign vld_o   = vld_q;
    assign rdata_o = rdata_q;

endmodule

// File: tb/tb_tcdm_varlat_bank_adapter.sv
// Testbench for tcdm_varlat_bank_adapter.
// Two instances share one stimulus stream: dut0 (MemLatency=1, WriteResp=1)
// and dut1 (MemLatency=3, WriteResp=0). Each instance has its own SRAM stub.
// A behavioural model keeps a history of accepted transactions indexed by
// cycle, plus a reference memory. Every cycle it predicts grant, SRAM drive,
// ready and response. Directed sequences add literal expectations.
// Build with +define+TCDM_BANK_INIT_EN to exercise the zero-fill sweep.

module tb_tcdm_varlat_bank_adapter;

    localparam int AW   = 10;
    localparam int DW   = 32;
    localparam int BW   = 4;
    localparam int RDW  = 1 + BW + AW + DW;
    localparam int NW   = 1 << AW;
    localparam int HIST = 16384;
`ifdef TCDM_BANK_INIT_EN
    localparam int INIT_N = NW;
`else
    localparam int INIT_N = 0;
`endif

    logic           clk_i = 1'b0;
    logic           rst_ni;
    logic           req_i;
    logic           mem_stall_i;
    logic [RDW-1:0] data_i;

    logic          gnt0, vld0, mreq0, mwe0, idone0;
    logic [DW-1:0] rdata0, mwdata0, mrdata0;
    logic [BW-1:0] mbe0;
    logic [AW-1:0] maddr0;
    logic          gnt1, vld1, mreq1, mwe1, idone1;
    logic [DW-1:0] rdata1, mwdata1, mrdata1;
    logic [BW-1:0] mbe1;
    logic [AW-1:0] maddr1;

    always #5 clk_i = ~clk_i;

    tcdm_varlat_bank_adapter #(
        .AddrWidth(AW), .DataWidth(DW), .BeWidth(BW), .ReqDataWidth(RDW),
        .MemLatency(1), .WriteResp(1)
    ) dut0 (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(gnt0), .data_i(data_i),
        .vld_o(vld0), .rdata_o(rdata0), .mem_req_o(mreq0), .mem_we_o(mwe0),
        .mem_be_o(mbe0), .mem_addr_o(maddr0), .mem_wdata_o(mwdata0),
        .mem_rdata_i(mrdata0), .mem_stall_i(mem_stall_i), .init_done_o(idone0)
    );

    tcdm_varlat_bank_adapter #(
        .AddrWidth(AW), .DataWidth(DW), .BeWidth(BW), .ReqDataWidth(RDW),
        .MemLatency(3), .WriteResp(0)
    ) dut1 (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(gnt1), .data_i(data_i),
        .vld_o(vld1), .rdata_o(rdata1), .mem_req_o(mreq1), .mem_we_o(mwe1),
        .mem_be_o(mbe1), .mem_addr_o(maddr1), .mem_wdata_o(mwdata1),
        .mem_rdata_i(mrdata1), .mem_stall_i(mem_stall_i), .init_done_o(idone1)
    );

    function automatic logic [31:0] init_word(input int i);
        return (32'(i) * 32'h9E37_79B9) ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    // ---------------- SRAM stubs (fixed read latency 1 and 3) ----------------
    logic [31:0] smem0 [NW];
    logic [31:0] smem1 [NW];
    logic [31:0] rp0;
    logic [31:0] rp1 [3];

    initial begin
        for (int i = 0; i < NW; i++) begin
            smem0[i] <= init_word(i);
            smem1[i] <= init_word(i);
        end
    end

    always @(posedge clk_i) begin
        if (mreq0 && mwe0) smem0[maddr0] <= merge(smem0[maddr0], mwdata0, mbe0);
        rp0 <= (mreq0 && !mwe0) ? smem0[maddr0] : $urandom();
        if (mreq1 && mwe1) smem1[maddr1] <= merge(smem1[maddr1], mwdata1, mbe1);
        rp1[0] <= (mreq1 && !mwe1) ? smem1[maddr1] : $urandom();
        rp1[1] <= rp1[0];
        rp1[2] <= rp1[1];
    end

    assign mrdata0 = rp0;
    assign mrdata1 = rp1[2];

    // ---------------- behavioural model state ----------------
    int          cyc      = 0;
    int          last_rst = -100;
    int          init_rem = 0;
    bit          acc_v [HIST];
    bit          acc_w [HIST];
    logic [31:0] acc_d [HIST];
    logic [31:0] ref_mem [NW];
    int          n_pass = 0;
    int          n_chk  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, cyc, act, exp);
    endtask

    // Response expected in this cycle for an instance of the given latency.
    task automatic resp_check(input string tag, input int lat, input bit wr,
                              input logic vld, input logic [31:0] rd);
        int a;
        bit live, ev;
        logic [31:0] d;
        a = cyc - lat - 1;
        live = 1'b0;
        ev = 1'b0;
        d = '0;
        if (a >= 0) begin
            live = acc_v[a % HIST] && (last_rst < a);
            ev   = live && (!acc_w[a % HIST] || wr);
            d    = acc_d[a % HIST];
        end
        chk({tag, "_vld"}, 64'(vld), 64'(ev));
        if (ev) chk({tag, "_rdata"}, 64'(rd), 64'(d));
        else if (live || (last_rst == cyc - 1)) chk({tag, "_rdata_zero"}, 64'(rd), 64'h0);
    endtask

    task automatic model_step();
        logic          wen, ready, exp_gnt, exp_iw;
        logic [3:0]    be;
        logic [AW-1:0] addr, iaddr;
        logic [31:0]   wd;
        logic [63:0]   exp_mem;
        {wen, be, addr, wd} = data_i;
        ready   = (init_rem == 0);
        exp_gnt = rst_ni && req_i && !mem_stall_i && ready;
        exp_iw  = rst_ni && !ready && !mem_stall_i;
        iaddr   = AW'(INIT_N - init_rem);
        exp_mem = '0;
        if (exp_gnt)     exp_mem = {16'h0, 1'b1, wen, be, addr, wd};
        else if (exp_iw) exp_mem = {16'h0, 2'b11, 4'hF, iaddr, 32'h0};
        if (cyc >= 1) begin
            chk("gnt0", 64'(gnt0), 64'(exp_gnt));
            chk("gnt1", 64'(gnt1), 64'(exp_gnt));
            chk("mem0", {16'h0, mreq0, mwe0, mbe0, maddr0, mwdata0}, exp_mem);
            chk("mem1", {16'h0, mreq1, mwe1, mbe1, maddr1, mwdata1}, exp_mem);
            chk("init_done0", 64'(idone0), 64'(ready && (last_rst != cyc - 1)));
            chk("init_done1", 64'(idone1), 64'(ready && (last_rst != cyc - 1)));
            resp_check("dut0", 1, 1'b1, vld0, rdata0);
            resp_check("dut1", 3, 1'b0, vld1, rdata1);
        end
        acc_v[cyc % HIST] = exp_gnt;
        acc_w[cyc % HIST] = wen;
        acc_d[cyc % HIST] = wen ? 32'h0 : ref_mem[addr];
        if (exp_gnt && wen) ref_mem[addr] = merge(ref_mem[addr], wd, be);
        if (exp_iw) ref_mem[iaddr] = '0;
        if (!rst_ni) begin
            init_rem = INIT_N;
            last_rst = cyc;
        end else if (exp_iw) begin
            init_rem--;
        end
        cyc++;
    endtask

    task automatic sample();
        @(negedge clk_i);
        model_step();
    endtask

    task automatic adv();
        @(posedge clk_i);
        #1;
    endtask

    task automatic tick();
        sample();
        adv();
    endtask

    task automatic drive(input logic wen, input logic [3:0] be, input logic [AW-1:0] addr,
                         input logic [31:0] wd);
        req_i  = 1'b1;
        data_i = {wen, be, addr, wd};
    endtask

    task automatic idle();
        req_i  = 1'b0;
        data_i = RDW'({$urandom(), $urandom()});
    endtask

    // Wait (bounded) for both instances to report ready; optional 2-cycle stall.
    task automatic wait_init(input int stall_at, input int exp_k);
        int k;
        bit done;
        k = 0;
        done = 1'b0;
        while (!done && k < 3000) begin
            mem_stall_i = (k == stall_at) || (k == stall_at + 1);
            sample();
            if (k < 4) chk("post_rst_vld", {62'h0, vld0, vld1}, 64'h0);
            if (k == 0) chk("post_rst_rdata0", 64'(rdata0), 64'h0);
            if (idone0 && idone1) done = 1'b1;
            else begin
                adv();
                k++;
            end
        end
        chk("init_cycles", 64'(k), 64'(exp_k));
        adv();
        mem_stall_i = 1'b0;
    endtask

    initial begin
        int np;
        for (int i = 0; i < NW; i++) ref_mem[i] = init_word(i);
        rst_ni = 1'b0;
        req_i = 1'b0;
        mem_stall_i = 1'b0;
        data_i = '0;
        repeat (2) tick();
        sample();
        chk("rst_vld0", 64'(vld0), 64'h0);
        chk("rst_rdata0", 64'(rdata0), 64'h0);
        chk("rst_idone0", 64'(idone0), 64'h0);
        chk("rst_vld1", 64'(vld1), 64'h0);
        adv();
        rst_ni = 1'b1;
        wait_init(100, (INIT_N > 0) ? INIT_N + 2 : 1);

        // Write 0xDEADBEEF to 0x005, then read it back.
        drive(1'b1, 4'hF, 10'h005, 32'hDEADBEEF);
        sample();
        chk("wr_gnt", 64'(gnt0), 64'h1);
        chk("wr_mem", {16'h0, mreq0, mwe0, mbe0, maddr0, mwdata0},
            {16'h0, 1'b1, 1'b1, 4'hF, 10'h005, 32'hDEADBEEF});
        adv();
        drive(1'b0, 4'hF, 10'h005, 32'h0);
        sample();
        chk("rd_gnt", 64'(gnt0), 64'h1);
        chk("rd_we", 64'(mwe0), 64'h0);
        chk("rd_addr", 64'(maddr0), 64'h005);
        adv();
        idle();
        sample();
        chk("wresp_vld0", 64'(vld0), 64'h1);
        chk("wresp_rdata0", 64'(rdata0), 64'h0);
        adv();
        sample();
        chk("rd_vld0", 64'(vld0), 64'h1);
        chk("rd_rdata0", 64'(rdata0), 64'hDEADBEEF);
        adv();
        sample();
        chk("rd_single0", 64'(vld0), 64'h0);
        chk("wr_noresp1", 64'(vld1), 64'h0);
        adv();
        sample();
        chk("rd_vld1", 64'(vld1), 64'h1);
        chk("rd_rdata1", 64'(rdata1), 64'hDEADBEEF);
        adv();

        // Partial write to the top address.
        drive(1'b1, 4'b0011, 10'h3FF, 32'hCAFE0000);
        sample();
        chk("cafe_mem", {16'h0, mreq0, mwe0, mbe0, maddr0, mwdata0},
            {16'h0, 1'b1, 1'b1, 4'b0011, 10'h3FF, 32'hCAFE0000});
        adv();
        idle();
        tick();
        sample();
        chk("cafe_vld0", 64'(vld0), 64'h1);
        chk("cafe_rdata0", 64'(rdata0), 64'h0);
        adv();
        repeat (4) tick();

        // Streaming: 8 back-to-back reads, count dut1 pulses.
        np = 0;
        for (int i = 0; i < 16; i++) begin
            if (i < 8) drive(1'b0, 4'hF, AW'(i), 32'h0);
            else idle();
            sample();
            if (vld1) np++;
            adv();
        end
        chk("stream_pulses1", 64'(np), 64'd8);

        // Stall with two reads in flight.
        drive(1'b0, 4'hF, 10'h001, 32'h0);
        tick();
        drive(1'b0, 4'hF, 10'h002, 32'h0);
        tick();
        drive(1'b0, 4'hF, 10'h009, 32'h0);
        mem_stall_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sample();
            chk("stall_gnt", 64'(gnt0), 64'h0);
            adv();
        end
        mem_stall_i = 1'b0;
        sample();
        chk("unstall_gnt", 64'(gnt0), 64'h1);
        adv();
        idle();
        repeat (6) tick();

        // Reset while a read is in flight.
        drive(1'b0, 4'hF, 10'h005, 32'h0);
        tick();
        idle();
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        wait_init(-10, (INIT_N > 0) ? INIT_N : 1);

        // Randomised traffic with stalls and occasional resets.
        for (int i = 0; i < 2500; i++) begin
            rst_ni      = ($urandom_range(0, 599) != 0);
            req_i       = ($urandom_range(0, 3) != 0);
            mem_stall_i = ($urandom_range(0, 7) == 0);
            data_i      = {1'($urandom()), 4'($urandom()), AW'($urandom_range(0, 15)), $urandom()};
            tick();
        end
        rst_ni = 1'b1;
        mem_stall_i = 1'b0;
        idle();
        repeat (8) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/tcdm_varlat_bank_adapter.md
Name: tcdm_varlat_bank_adapter

Overview:
Target-side stage placed directly downstream of one output port k of the variable-latency crossbar. Unpacks the crossbar's flat request payload into SRAM control fields and drives one fixed-latency SRAM bank. Converts the bank's fixed read latency into the crossbar's gnt/vld handshake. Withholds grant while the bank is stalled and, optionally, while the bank is being zero-initialised after reset.

Parameters:
AddrWidth, 10, bank word-address width.
DataWidth, 32, data word width.
BeWidth, DataWidth/8, byte-enable width.
ReqDataWidth, 1+BeWidth+AddrWidth+DataWidth, packed payload width; must equal the crossbar ReqDataWidth.
MemLatency, 1, SRAM read latency in cycles (mem_req_o to mem_rdata_i); valid range 1..4.
WriteResp, 1, 1 = pulse vld_o for writes; 0 = reads only.

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, synchronous, active-low
req_i  in  1  request from crossbar req_o[k]
gnt_o  out  1  grant to crossbar gnt_i[k]
data_i  in  ReqDataWidth  payload {wen, be, addr, wdata}, MSB first; wen=1 means write
vld_o  out  1  response valid to crossbar vld_i[k]
rdata_o  out  DataWidth  response data to crossbar rdata_i[k]
mem_req_o  out  1  SRAM chip enable
mem_we_o  out  1  SRAM write enable
mem_be_o  out  BeWidth  SRAM byte enables
mem_addr_o  out  AddrWidth  SRAM address
mem_wdata_o  out  DataWidth  SRAM write data
mem_rdata_i  in  DataWidth  SRAM read data, valid MemLatency cycles after the accepting cycle
mem_stall_i  in  1  bank busy (e.g. scrub); blocks new grants
init_done_o  out  1  bank ready for traffic

Behaviour:
- Accept condition: gnt_o = req_i & ~mem_stall_i & (state==RUN). This is combinational, as the crossbar arbiter requires.
- mem_req_o = gnt_o in RUN. mem_we_o, mem_be_o, mem_addr_o and mem_wdata_o are taken from data_i fields in RUN; they are driven to 0 when mem_req_o is 0.
- Tracking pipeline: a shift register of depth MemLatency carries {valid, is_write}. Stage 0 is loaded on accept.
- Response: at the pipeline tail, rdata_o is registered from mem_rdata_i for reads and set to 0 for writes. vld_o is registered high when (tail.valid & (~tail.is_write | WriteResp)).
- Total latency: vld_o is high exactly MemLatency+1 cycles after the accept cycle. The result is a one-cycle pulse per accepted transaction.
- Throughput: one accept per cycle. Back-to-back accepts give back-to-back vld_o pulses in the same order.
- No backpressure on responses. In-flight responses complete even if mem_stall_i rises.
- mem_stall_i only blocks new accepts. If req_i is held while stalled, the request is granted in the first cycle stall drops.
- FSM states: INIT, RUN.
  - INIT exists only with the optional feature; otherwise reset enters RUN directly.
  - init_done_o = (state==RUN), registered.
- Reset (rst_ni=0 at a clock edge):
  - Pipeline is cleared; in-flight responses are dropped.
  - vld_o=0, rdata_o=0, init_done_o=0 (it becomes 1 on the first cycle after reset if no INIT).
  - Init counter is set to 0.
- Reset mid-operation: no vld_o for transactions accepted before reset. No SRAM access in the reset cycle.

Optional Feature:
Macro: TCDM_BANK_INIT_EN
- Defined:
  - Reset enters INIT. A counter sweeps addresses 0..2^AddrWidth-1, one write per cycle: mem_req_o=1, mem_we_o=1, mem_be_o=all-ones, mem_wdata_o=0.
  - mem_stall_i pauses the sweep: no write that cycle, counter holds.
  - gnt_o=0 throughout INIT. Init writes never produce vld_o.
  - After the write to the last address, the FSM moves to RUN on the next cycle and init_done_o=1.
  - Counter wrap-around must not re-enter INIT.
- Undefined: no counter and no INIT state. RUN is entered one cycle after reset release.

Test Plan:
- Read path: MemLatency=1; reset, RUN. req_i=1 with read to addr 0x05; SRAM returns 0xDEADBEEF -> gnt_o=1 same cycle; mem_addr_o=0x05, mem_we_o=0; vld_o=1 with rdata_o=0xDEADBEEF exactly 2 cycles later, single pulse.
- Write plus WriteResp: WriteResp=1, write 0xCAFE0000 with be=4'b0011 to 0x3FF -> mem_we_o=1, mem_be_o=0011, mem_wdata_o=0xCAFE0000; vld_o pulse with rdata_o=0 after 2 cycles. With WriteResp=0, no vld_o.
- Streaming: MemLatency=3; 8 consecutive reads to addresses 0..7 -> 8 grants, 8 consecutive vld_o pulses starting 4 cycles after the first accept, data in order.
- Stall: hold req_i with mem_stall_i=1 for 5 cycles while 2 reads are in flight -> gnt_o=0 for 5 cycles; both in-flight vld_o still arrive on time; grant in the first cycle after stall drops.
- Reset mid-flight: accept read, assert rst_ni=0 next cycle -> no vld_o for that read; vld_o=0 and rdata_o=0 after reset.
- TCDM_BANK_INIT_EN, AddrWidth=4: after reset -> 16 zero writes, addresses 0..15, gnt_o=0 throughout; 2-cycle mem_stall_i mid-sweep extends INIT by 2 cycles; init_done_o=1 afterwards and the next req_i is granted.
